tile_turn_controller: RTL

//  Sequences one player turn of the tile-matching game: takes the first and second tile picks, fetches

---
 rtl/tile_turn_controller_pkg.sv | 49 ++++
 rtl/tile_turn_controller_pick_decoder.sv | 40 ++++
 rtl/tile_turn_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_turn_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tile_turn_controller_pkg
//  Description : Shared types, widths and the one-hot pick decode helper for
//                the tile-matching turn controller.
//  Revision    : 1.0  initial release
// ============================================================================
package tile_turn_controller_pkg;

  localparam int MOVE_W    = 8;
  localparam int IDX_W     = 4;
  localparam int MAX_TILES = 1 << IDX_W;

  // Turn sequencing states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_FIRST  = 3'd1,
    S_READ_FIRST  = 3'd2,
    S_WAIT_SECOND = 3'd3,
    S_READ_SECOND = 3'd4,
    S_COMPARE     = 3'd5,
    S_REVEAL      = 3'd6,
    S_DONE        = 3'd7
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // valid is set only when exactly one switch is up; idx is its position
  function automatic pick_t onehot_decode(input logic [MAX_TILES-1:0] sw);
    pick_t r;
    int    n;
    r.valid = 1'b0;
    r.idx   = '0;
    n       = 0;
    for (int i = 0; i < MAX_TILES; i++) begin
      if (sw[i]) begin
        n     = n + 1;
        r.idx = IDX_W'(i);
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_turn_controller_pick_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tile_pick_decoder
//  Description : Turns the switch bank into a tile index and decides whether
//                the pick is usable: exactly one switch, tile not already
//                matched, and (for the second pick) not the first tile again.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_pick_decoder
  import tile_turn_controller_pkg::*;
#(
  parameter int NUM_TILES = 10
) (
  input  logic [NUM_TILES-1:0] i_tile_sw,
  input  logic [NUM_TILES-1:0] i_matched,
  input  logic                 i_check_dup,
  input  logic [IDX_W-1:0]     i_first_idx,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_idx,
  output logic [NUM_TILES-1:0] o_onehot
);

  logic [MAX_TILES-1:0] w_sw_ext;
  pick_t                w_dec;
  logic                 w_hits_matched;
  logic                 w_is_dup;

  // Decode the switches and apply the matched / duplicate filters
  always_comb begin
    w_sw_ext       = MAX_TILES'(i_tile_sw);
    w_dec          = onehot_decode(w_sw_ext);
    w_hits_matched = |(i_tile_sw & i_matched);
    w_is_dup       = i_check_dup && (w_dec.idx == i_first_idx);
    o_valid        = w_dec.valid && !w_hits_matched && !w_is_dup;
    o_idx          = w_dec.idx;
    o_onehot       = i_tile_sw;
  end

endmodule
`default_nettype wire

// File: rtl/tile_turn_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tile_turn_controller
//  Description : Sequences one player turn: two picks, two board reads over a
//                req/ack port, compare, matched/revealed mask update, move
//                counting and game-over detection.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_turn_controller
  import tile_turn_controller_pkg::*;
#(
  parameter int NUM_TILES     = 10,
  parameter int VAL_W         = 3,
  parameter int REVEAL_CYCLES = 50_000_000
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 quit,
  input  logic                 select1,
  input  logic                 select2,
  input  logic [NUM_TILES-1:0] tile_sw,
  output logic                 rd_req,
  output logic [IDX_W-1:0]     rd_idx,
  input  logic                 rd_ack,
  input  logic [VAL_W-1:0]     rd_data,
  output logic [NUM_TILES-1:0] revealed,
  output logic [NUM_TILES-1:0] matched,
  output logic [MOVE_W-1:0]    move_count,
  output logic                 match_pulse,
  output logic                 miss_pulse,
  output logic                 game_over,
  output logic                 busy
);

  // +1 keeps the width non-zero when REVEAL_CYCLES is 1
  localparam int                   CNT_W         = $clog2(REVEAL_CYCLES + 1);
  localparam logic [CNT_W-1:0]     c_reveal_load = CNT_W'(REVEAL_CYCLES - 1);
  localparam logic [NUM_TILES-1:0] c_all_tiles   = '1;

  // Registered state
  state_t                 r_state;
  logic                   r_sel1_q;
  logic                   r_sel2_q;
  logic [IDX_W-1:0]       r_idx1;
  logic [IDX_W-1:0]       r_idx2;
  logic [VAL_W-1:0]       r_val1;
  logic [VAL_W-1:0]       r_val2;
  logic [NUM_TILES-1:0]   r_pick;
  logic [NUM_TILES-1:0]   r_matched;
  logic [MOVE_W-1:0]      r_moves;
  logic                   r_match_pulse;
  logic                   r_miss_pulse;
  logic                   r_rd_req;
  logic [CNT_W-1:0]       r_cnt;

  // Next-state values
  state_t                 w_state_n;
  logic [IDX_W-1:0]       w_idx1_n;
  logic [IDX_W-1:0]       w_idx2_n;
  logic [VAL_W-1:0]       w_val1_n;
  logic [VAL_W-1:0]       w_val2_n;
  logic [NUM_TILES-1:0]   w_pick_n;
  logic [NUM_TILES-1:0]   w_matched_n;
  logic [MOVE_W-1:0]      w_moves_n;
  logic                   w_match_pulse_n;
  logic                   w_miss_pulse_n;
  logic                   w_rd_req_n;
  logic [CNT_W-1:0]       w_cnt_n;

  logic                   w_sel1_edge;
  logic                   w_sel2_edge;
  logic                   w_pick_valid;
  logic [IDX_W-1:0]       w_pick_idx;
  logic [NUM_TILES-1:0]   w_pick_onehot;

  assign w_sel1_edge = select1 & ~r_sel1_q;
  assign w_sel2_edge = select2 & ~r_sel2_q;

  tile_pick_decoder #(
    .NUM_TILES (NUM_TILES)
  ) u_pick_decoder (
    .i_tile_sw   (tile_sw),
    .i_matched   (r_matched),
    .i_check_dup (r_state == S_WAIT_SECOND),
    .i_first_idx (r_idx1),
    .o_valid     (w_pick_valid),
    .o_idx       (w_pick_idx),
    .o_onehot    (w_pick_onehot)
  );

  // Key history for edge detection; runs in every state so edges seen
  // during REVEAL are consumed rather than queued
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sel1_q <= 1'b0;
      r_sel2_q <= 1'b0;
    end else begin
      r_sel1_q <= select1;
      r_sel2_q <= select2;
    end
  end

  // Turn FSM next-state and datapath updates
  always_comb begin
    w_state_n       = r_state;
    w_idx1_n        = r_idx1;
    w_idx2_n        = r_idx2;
    w_val1_n        = r_val1;
    w_val2_n        = r_val2;
    w_pick_n        = r_pick;
    w_matched_n     = r_matched;
    w_moves_n       = r_moves;
    w_match_pulse_n = 1'b0;
    w_miss_pulse_n  = 1'b0;
    w_rd_req_n      = 1'b0;
    w_cnt_n         = r_cnt;

    if (quit || !enable) begin
      // Abort from anywhere: drop any outstanding read and wipe the game
      w_state_n   = S_IDLE;
      w_idx1_n    = '0;
      w_idx2_n    = '0;
      w_val1_n    = '0;
      w_val2_n    = '0;
      w_pick_n    = '0;
      w_matched_n = '0;
      w_moves_n   = '0;
      w_cnt_n     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_n = S_WAIT_FIRST;
        end
        S_WAIT_FIRST: begin
          if (w_sel1_edge && w_pick_valid) begin
            w_idx1_n  = w_pick_idx;
            w_pick_n  = r_pick | w_pick_onehot;
            w_state_n = S_READ_FIRST;
          end
        end
        S_READ_FIRST: begin
          // ack only counts once the request is actually on the port
          if (r_rd_req && rd_ack) begin
            w_val1_n  = rd_data;
            w_state_n = S_WAIT_SECOND;
          end else begin
            w_rd_req_n = 1'b1;
          end
        end
        S_WAIT_SECOND: begin
          if (w_sel2_edge && w_pick_valid) begin
            w_idx2_n  = w_pick_idx;
            w_pick_n  = r_pick | w_pick_onehot;
            w_state_n = S_READ_SECOND;
          end
        end
        S_READ_SECOND: begin
          if (r_rd_req && rd_ack) begin
            w_val2_n  = rd_data;
            w_state_n = S_COMPARE;
          end else begin
            w_rd_req_n = 1'b1;
          end
        end
        S_COMPARE: begin
          if (r_moves != {MOVE_W{1'b1}}) begin
            w_moves_n = r_moves + MOVE_W'(1);
          end
          if (r_val1 == r_val2) begin
            w_matched_n     = r_matched | r_pick;
            w_pick_n        = '0;
            w_match_pulse_n = 1'b1;
            w_state_n       = (w_matched_n == c_all_tiles) ? S_DONE : S_WAIT_FIRST;
          end else begin
            w_miss_pulse_n = 1'b1;
            w_cnt_n        = c_reveal_load;
            w_state_n      = S_REVEAL;
          end
        end
        S_REVEAL: begin
          if (r_cnt == '0) begin
            w_pick_n  = '0;
            w_state_n = S_WAIT_FIRST;
          end else begin
            w_cnt_n = r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          w_state_n = S_DONE;
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  // Turn FSM state and datapath registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_idx1        <= '0;
      r_idx2        <= '0;
      r_val1        <= '0;
      r_val2        <= '0;
      r_pick        <= '0;
      r_matched     <= '0;
      r_moves       <= '0;
      r_match_pulse <= 1'b0;
      r_miss_pulse  <= 1'b0;
      r_rd_req      <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_n;
      r_idx1        <= w_idx1_n;
      r_idx2        <= w_idx2_n;
      r_val1        <= w_val1_n;
      r_val2        <= w_val2_n;
      r_pick        <= w_pick_n;
      r_matched     <= w_matched_n;
      r_moves       <= w_moves_n;
      r_match_pulse <= w_match_pulse_n;
      r_miss_pulse  <= w_miss_pulse_n;
      r_rd_req      <= w_rd_req_n;
      r_cnt         <= w_cnt_n;
    end
  end

  // Outputs are decoded straight from registers
  always_comb begin
    rd_req      = r_rd_req;
    rd_idx      = '0;
    if (r_state == S_READ_FIRST) begin
      rd_idx = r_idx1;
    end else if (r_state == S_READ_SECOND) begin
      rd_idx = r_idx2;
    end
    revealed    = r_matched | r_pick;
    matched     = r_matched;
    move_count  = r_moves;
    match_pulse = r_match_pulse;
    miss_pulse  = r_miss_pulse;
    game_over   = (r_state == S_DONE);
    busy        = (r_state == S_READ_FIRST)  || (r_state == S_READ_SECOND) ||
                  (r_state == S_COMPARE)     || (r_state == S_REVEAL);
  end

endmodule
`default_nettype wire
